lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the execute path.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Runs one data-memory transaction over a valid/ready bus and returns extended load data to the writeback mux.
- Stalls the core until the access completes, errors or times out.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for mem_ready before abort. 0 means wait forever.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  current instruction is a load/store
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010)
- req_addr  in  32  effective address (ALU out)
- req_wdata  in  32  rs2 store data
- stall  out  1  hold PC / regfile write
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data
- resp_err  out  1  access failed (valid with resp_valid)
- resp_misalign  out  1  failure cause was misalignment (valid with resp_valid)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address, bits[1:0]=00
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus accepts/completes this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1
- mem_err  in  1  bus error, valid when mem_ready=1

Behaviour:
- Reset: state=IDLE. All outputs 0, timeout counter 0. A reset mid-transaction drops mem_req at the next edge and abandons the access; no resp_valid is produced.
- States: IDLE, BUS, DONE.
- stall = (IDLE & req_valid) | BUS. It is 0 in DONE.
- IDLE, req_valid=1, request legal: latch mem_addr={req_addr[31:2],2'b00}, mem_we, mem_be, mem_wdata, offset and funct3. Set mem_req=1, clear counter, go to BUS.
- IDLE, req_valid=1, request illegal: go to DONE with resp_err=1, no bus access. Illegal means load funct3 011/110/111, store funct3 other than 000/001/010, or misaligned (see optional feature).
- BUS: mem_* outputs are held stable while mem_req=1.
  - mem_ready=1: mem_req→0, capture result, go to DONE. resp_err=mem_err.
  - mem_ready=0: counter increments. If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 without ready, mem_req→0, go to DONE with resp_err=1.
- DONE: resp_valid=1 for exactly this cycle, then IDLE. req_valid is ignored in DONE because the core retires the instruction at this edge. This prevents re-issuing the same instruction.
- Minimum latency with mem_ready already high: 2 cycles (IDLE→BUS→DONE).
- Store lanes (off=req_addr[1:0]):
  - SB: be=4'b0001<<off, wdata={4{rs2[7:0]}}.
  - SH: be=off[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Load extraction: select byte/half at the latched offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Loads use mem_be as for stores of the same width.
- resp_rdata:
  - updated only on load completion;
  - 0 on a load that errors or times out;
  - held (not updated) on stores.
- resp_err and resp_misalign are 0 whenever resp_valid=0.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, make no bus access. The block goes IDLE→DONE with resp_err=1 and resp_misalign=1.
- Undefined: low address bits are forced to alignment (addr[0] ignored for halves, addr[1:0] ignored for words), the access proceeds normally, and resp_misalign is tied 0.

Test Plan:
- LB: addr 0x1003, mem_rdata 0x80AB_CDEF, ready on first BUS cycle → mem_addr 0x1000, mem_be 1000. Two cycles later resp_valid=1, resp_rdata 0xFFFF_FF80. stall high for 2 cycles.
- SH: addr 0x2002, rs2 0x1234_5678, ready delayed 3 cycles → mem_be 1100, mem_wdata 0x5678_5678. mem_* stable for all 4 BUS cycles. resp_rdata unchanged.
- LW with mem_ready never asserted, TIMEOUT_CYCLES=16 → mem_req drops after 16 BUS cycles, then resp_valid=1, resp_err=1, resp_rdata 0.
- LW addr 0x3001: with LSU_MISALIGN_TRAP_EN → mem_req never rises; resp_err=1, resp_misalign=1 in 2nd cycle. Without it → mem_addr 0x3000, be 1111, resp_err=0.
- Back-to-back LBU 0x10 then SW 0x14, ready immediately → second request issues the cycle after DONE. Exactly one resp_valid per instruction; LBU of 0xFF gives 0x0000_00FF.
- rst=1 during BUS → next cycle mem_req=0, stall=0, resp_valid=0, state IDLE. A fresh request after rst=0 completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: issues one data-memory access per load/store over a valid/ready bus
// and returns extended load data. Optional macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses).
module lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_BUS  = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;
    localparam logic        TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic [1:0]  state_r;
    logic [31:0] cnt_r;
    logic [1:0]  off_r;
    logic [2:0]  funct3_r;

    logic [1:0]  off_s;
    logic        legal_s;
    logic        misalign_s;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return w;
        endcase
    endfunction

    assign stall = ((state_r == ST_IDLE) && req_valid) || (state_r == ST_BUS);

    // Request decode: funct3 legality, lane offset and misalignment detection
    always_comb begin
        off_s      = req_addr[1:0];
        misalign_s = 1'b0;
        if (req_we) begin
            legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   misalign_s = legal_s && req_addr[0];
            2'b10:   misalign_s = legal_s && (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
`else
        // Without the trap, low address bits below the access size are simply dropped.
        case (req_funct3[1:0])
            2'b01:   off_s = {req_addr[1], 1'b0};
            2'b10:   off_s = 2'b00;
            default: off_s = req_addr[1:0];
        endcase
`endif
    end

    // Transaction FSM, bus request registers and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 32'd0;
            off_r         <= 2'b00;
            funct3_r      <= 3'b000;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_be        <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid    <= 1'b0;
                    resp_err      <= 1'b0;
                    resp_misalign <= 1'b0;
                    if (req_valid && legal_s && !misalign_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= lane_be(req_funct3[1:0], off_s);
                        mem_wdata <= lane_wdata(req_funct3[1:0], req_wdata);
                        off_r     <= off_s;
                        funct3_r  <= req_funct3;
                        cnt_r     <= 32'd0;
                        state_r   <= ST_BUS;
                    end else if (req_valid) begin
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_misalign <= misalign_s;
                        if (!req_we) begin
                            resp_rdata <= 32'd0;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_err;
                        if (!mem_we) begin
                            resp_rdata <= mem_err ? 32'd0 : load_extract(funct3_r, off_r, mem_rdata);
                        end
                        state_r <= ST_DONE;
                    end else if (TIMEOUT_EN && (cnt_r == TIMEOUT_LAST)) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        if (!mem_we) begin
                            resp_rdata <= 32'd0;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    // The core retires the instruction on this edge, so req_valid is not looked at.
                    resp_valid    <= 1'b0;
                    resp_err      <= 1'b0;
                    resp_misalign <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    mem_req       <= 1'b0;
                    resp_valid    <= 1'b0;
                    resp_err      <= 1'b0;
                    resp_misalign <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads, stores, timeout, misalignment,
// back-to-back issue and mid-transaction reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_misalign(resp_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    initial begin
        int rv_cnt;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;

        // Reset state
        tick(); tick(); neg();
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_be", {28'd0, mem_be}, 32'd0);
        tick(); rst = 1'b0;
        neg();

        // LB at 0x1003, ready immediately
        tick(); issue(1'b0, 3'b000, 32'h0000_1003, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h80AB_CDEF;
        neg();
        check_eq("lb_stall_idle", {31'd0, stall}, 32'd1);
        check_eq("lb_req_idle", {31'd0, mem_req}, 32'd0);
        tick(); neg();
        check_eq("lb_req", {31'd0, mem_req}, 32'd1);
        check_eq("lb_addr", mem_addr, 32'h0000_1000);
        check_eq("lb_be", {28'd0, mem_be}, 32'h8);
        check_eq("lb_we", {31'd0, mem_we}, 32'd0);
        check_eq("lb_stall_bus", {31'd0, stall}, 32'd1);
        check_eq("lb_rv_bus", {31'd0, resp_valid}, 32'd0);
        tick(); neg();
        check_eq("lb_rv", {31'd0, resp_valid}, 32'd1);
        check_eq("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        check_eq("lb_err", {31'd0, resp_err}, 32'd0);
        check_eq("lb_stall_done", {31'd0, stall}, 32'd0);
        check_eq("lb_req_done", {31'd0, mem_req}, 32'd0);
        tick(); req_valid = 1'b0; mem_ready = 1'b0;
        neg();
        check_eq("lb_rv_after", {31'd0, resp_valid}, 32'd0);

        // SH at 0x2002, ready on the 4th BUS cycle
        tick(); issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678);
        neg();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            neg();
            check_eq("sh_req", {31'd0, mem_req}, 32'd1);
            check_eq("sh_we", {31'd0, mem_we}, 32'd1);
            check_eq("sh_addr", mem_addr, 32'h0000_2000);
            check_eq("sh_be", {28'd0, mem_be}, 32'hC);
            check_eq("sh_wdata", mem_wdata, 32'h5678_5678);
            check_eq("sh_rv_bus", {31'd0, resp_valid}, 32'd0);
        end
        tick(); neg();
        check_eq("sh_rv", {31'd0, resp_valid}, 32'd1);
        check_eq("sh_err", {31'd0, resp_err}, 32'd0);
        check_eq("sh_rdata_held", resp_rdata, 32'hFFFF_FF80);
        tick(); req_valid = 1'b0; mem_ready = 1'b0;
        neg();

        // LW timeout: ready never asserted
        tick(); issue(1'b0, 3'b010, 32'h0000_4000, 32'd0);
        neg();
        for (int i = 0; i < 16; i++) begin
            tick(); neg();
            check_eq("to_req_held", {31'd0, mem_req}, 32'd1);
            check_eq("to_rv_bus", {31'd0, resp_valid}, 32'd0);
        end
        tick(); neg();
        check_eq("to_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("to_rv", {31'd0, resp_valid}, 32'd1);
        check_eq("to_err", {31'd0, resp_err}, 32'd1);
        check_eq("to_rdata", resp_rdata, 32'd0);
        tick(); req_valid = 1'b0;
        neg();

        // LW at misaligned 0x3001
        tick(); issue(1'b0, 3'b010, 32'h0000_3001, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_BABE;
        neg();
`ifdef LSU_MISALIGN_TRAP_EN
        tick(); neg();
        check_eq("mis_req", {31'd0, mem_req}, 32'd0);
        check_eq("mis_rv", {31'd0, resp_valid}, 32'd1);
        check_eq("mis_err", {31'd0, resp_err}, 32'd1);
        check_eq("mis_flag", {31'd0, resp_misalign}, 32'd1);
        check_eq("mis_rdata", resp_rdata, 32'd0);
`else
        tick(); neg();
        check_eq("mis_req", {31'd0, mem_req}, 32'd1);
        check_eq("mis_addr", mem_addr, 32'h0000_3000);
        check_eq("mis_be", {28'd0, mem_be}, 32'hF);
        tick(); neg();
        check_eq("mis_rv", {31'd0, resp_valid}, 32'd1);
        check_eq("mis_err", {31'd0, resp_err}, 32'd0);
        check_eq("mis_flag", {31'd0, resp_misalign}, 32'd0);
        check_eq("mis_rdata", resp_rdata, 32'hCAFE_BABE);
`endif
        tick(); req_valid = 1'b0; mem_ready = 1'b0;
        neg();
        check_eq("mis_rv_after", {31'd0, resp_valid}, 32'd0);

        // Back-to-back LBU 0x10 then SW 0x14, ready always high
        rv_cnt = 0;
        tick(); issue(1'b0, 3'b100, 32'h0000_0010, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h0000_00FF;
        neg(); rv_cnt += int'(resp_valid);
        tick(); neg(); rv_cnt += int'(resp_valid);
        check_eq("b2b_lbu_be", {28'd0, mem_be}, 32'h1);
        tick(); neg(); rv_cnt += int'(resp_valid);
        check_eq("b2b_lbu_rdata", resp_rdata, 32'h0000_00FF);
        tick(); issue(1'b1, 3'b010, 32'h0000_0014, 32'hDEAD_BEEF);
        neg(); rv_cnt += int'(resp_valid);
        check_eq("b2b_no_reissue", {31'd0, mem_req}, 32'd0);
        check_eq("b2b_stall2", {31'd0, stall}, 32'd1);
        tick(); neg(); rv_cnt += int'(resp_valid);
        check_eq("b2b_sw_req", {31'd0, mem_req}, 32'd1);
        check_eq("b2b_sw_we", {31'd0, mem_we}, 32'd1);
        check_eq("b2b_sw_addr", mem_addr, 32'h0000_0014);
        check_eq("b2b_sw_be", {28'd0, mem_be}, 32'hF);
        check_eq("b2b_sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); neg(); rv_cnt += int'(resp_valid);
        check_eq("b2b_sw_rdata_held", resp_rdata, 32'h0000_00FF);
        tick(); req_valid = 1'b0; mem_ready = 1'b0;
        neg(); rv_cnt += int'(resp_valid);
        tick(); neg(); rv_cnt += int'(resp_valid);
        check_eq("b2b_resp_count", 32'(rv_cnt), 32'd2);

        // Reset during BUS, then a fresh LH
        tick(); issue(1'b0, 3'b010, 32'h0000_5000, 32'd0);
        neg();
        tick(); neg();
        check_eq("rb_req", {31'd0, mem_req}, 32'd1);
        tick(); rst = 1'b1; req_valid = 1'b0;
        neg();
        tick(); rst = 1'b0;
        neg();
        check_eq("rb_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("rb_stall", {31'd0, stall}, 32'd0);
        check_eq("rb_rv", {31'd0, resp_valid}, 32'd0);
        check_eq("rb_rdata", resp_rdata, 32'd0);
        tick(); neg();
        check_eq("rb_rv_quiet", {31'd0, resp_valid}, 32'd0);
        tick(); issue(1'b0, 3'b001, 32'h0000_5002, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h8001_1234;
        neg();
        tick(); neg();
        check_eq("rb_lh_addr", mem_addr, 32'h0000_5000);
        check_eq("rb_lh_be", {28'd0, mem_be}, 32'hC);
        tick(); neg();
        check_eq("rb_lh_rv", {31'd0, resp_valid}, 32'd1);
        check_eq("rb_lh_rdata", resp_rdata, 32'hFFFF_8001);
        tick(); req_valid = 1'b0; mem_ready = 1'b0;
        neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
